// File: rtl/sys_clk_pkg.sv
// sys_clk_pkg: shared state encoding and NCO defaults for the reset/clock-enable block
package sys_clk_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  localparam int ACC_W_DEF = 16;
  localparam int CPU_INC_DEF = 17039;
  localparam int PIX_INC_DEF = 34079;
endpackage

// File: rtl/nco_ce.sv
// nco_ce: phase-accumulator clock enable, one-cycle pulse on accumulator carry
module nco_ce #(
  parameter int ACC_W = 16,
  parameter int INC = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clr,
  output logic ce
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(INC);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      acc <= '0;
      ce <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ce <= 1'b0;
    end else if (run) begin
      acc <= sum[ACC_W-1:0];
      ce <= sum[ACC_W];
    end else
      ce <= 1'b0;
endmodule

// File: rtl/sys_reset_ce.sv
// sys_reset_ce: PLL lock synchroniser, system reset sequencer and CPU/pixel clock enables
module sys_reset_ce
  import sys_clk_pkg::*;
#(
  parameter int LOCK_HOLD = 1024,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CPU_INC = CPU_INC_DEF,
  parameter int PIX_INC = PIX_INC_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic locked,
  input  logic soft_rst,
  output logic sys_reset_n,
  output logic cpu_ce,
  output logic pix_ce,
  output logic running
);
  localparam int CNT_W = $clog2(LOCK_HOLD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_HOLD - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic lk_m, lk_s;
  logic run, clr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
      state <= WAIT_LOCK;
      cnt <= '0;
      sys_reset_n <= 1'b0;
    end else begin
      lk_m <= locked;
      lk_s <= lk_m;
      state <= state_nxt;
      cnt <= cnt_nxt;
      sys_reset_n <= state_nxt == RUN;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: state_nxt = lk_s ? HOLD : WAIT_LOCK;
      HOLD:      state_nxt = !lk_s ? WAIT_LOCK : (!soft_rst && cnt == LAST) ? RUN : HOLD;
      RUN:       state_nxt = !lk_s ? WAIT_LOCK : soft_rst ? HOLD : RUN;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end
  // counter only advances while staying in HOLD without a soft reset request
  assign cnt_nxt = (state == HOLD && state_nxt == HOLD && !soft_rst) ? cnt + 1'b1 : '0;
  assign running = sys_reset_n;
  assign clr = state_nxt == WAIT_LOCK;
  assign run = state != WAIT_LOCK;
  nco_ce #(.ACC_W(ACC_W), .INC(CPU_INC)) u_cpu (
    .clk(clk), .resetn(resetn), .run(run), .clr(clr), .ce(cpu_ce)
  );
  nco_ce #(.ACC_W(ACC_W), .INC(PIX_INC)) u_pix (
    .clk(clk), .resetn(resetn), .run(run), .clr(clr), .ce(pix_ce)
  );
endmodule

// File: tb/tb_sys_reset_ce.sv
// tb_sys_reset_ce: directed checks of reset sequencing and NCO enable rates
module tb_sys_reset_ce;
  logic clk = 1'b0, resetn = 1'b0, locked = 1'b0, soft_rst = 1'b0;
  logic a_rst, a_cpu, a_pix, a_run, b_rst, b_cpu, b_pix, b_run;
  int n_chk = 0, n_err = 0, rr_bad = 0;
  always #40 clk = ~clk;
  sys_reset_ce #(.LOCK_HOLD(8), .CPU_INC(16384)) u_a (
    .clk(clk), .resetn(resetn), .locked(locked), .soft_rst(soft_rst),
    .sys_reset_n(a_rst), .cpu_ce(a_cpu), .pix_ce(a_pix), .running(a_run)
  );
  sys_reset_ce #(.LOCK_HOLD(8)) u_b (
    .clk(clk), .resetn(resetn), .locked(locked), .soft_rst(soft_rst),
    .sys_reset_n(b_rst), .cpu_ce(b_cpu), .pix_ce(b_pix), .running(b_run)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    if (a_run != a_rst || b_run != b_rst) rr_bad++;
  endtask
  initial begin
    int fall, rise, first_ce, gap_bad, last_p, low_bad;
    int a_c, a_c4k, a_p, b_c, b_p, adj_a, adj_b, nr;
    logic pa, pb;
    tick;
    check("reset_outputs", {a_rst, a_cpu, a_pix, a_run, b_rst, b_cpu, b_pix, b_run}, 0);
    tick;
    resetn = 1'b1;
    low_bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (a_rst || a_run || a_cpu || a_pix || b_rst || b_cpu) low_bad++;
    end
    check("wait_lock_quiet", low_bad, 0);
    locked = 1'b1;
    rise = 0;
    first_ce = 0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (a_rst && rise == 0) rise = k;
      if (a_cpu && first_ce == 0) first_ce = k;
    end
    check("release_edge", rise, 11);
    check("first_cpu_ce_in_hold", first_ce, 7);
    check("b_released", b_rst, 1);
    locked = 1'b0;
    fall = 0;
    rise = 0;
    first_ce = 0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      if (k == 1) locked = 1'b1;
      if (!a_rst && fall == 0) fall = k;
      if (a_rst && fall != 0 && rise == 0) rise = k;
      if (k > 3 && a_cpu && first_ce == 0) first_ce = k;
      if (k == 3) check("ce_forced_low_on_wait", a_cpu, 0);
    end
    check("glitch_fall_edge", fall, 3);
    check("glitch_rise_edge", rise, 12);
    check("acc_cleared_restart", first_ce, 8);
    fall = 0;
    rise = 0;
    gap_bad = 0;
    last_p = 0;
    for (int k = 1; k <= 30; k++) begin
      soft_rst = (k >= 6 && k <= 8);
      tick;
      if (!a_rst && fall == 0) fall = k;
      if (a_rst && fall != 0 && rise == 0) rise = k;
      if (a_cpu) begin
        if (last_p != 0 && k - last_p != 4) gap_bad++;
        last_p = k;
      end
    end
    soft_rst = 1'b0;
    check("soft_rst_fall_edge", fall, 6);
    check("soft_rst_rise_edge", rise, 16);
    check("soft_rst_phase_kept", gap_bad, 0);
    soft_rst = 1'b1;
    tick;
    soft_rst = 1'b0;
    first_ce = 0;
    for (int k = 1; k <= 6 && first_ce == 0; k++) begin
      tick;
      if (a_cpu) first_ce = k;
    end
    check("hold_pulse_before_reset", a_cpu, 1);
    #20 resetn = 1'b0;
    #1;
    check("async_reset_outputs", {a_rst, a_cpu, a_pix, a_run, b_rst, b_cpu, b_pix, b_run}, 0);
    tick;
    tick;
    resetn = 1'b1;
    rise = 0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (a_rst && rise == 0) rise = k;
    end
    check("post_reset_release", rise, 11);
    a_c = 0; a_c4k = 0; a_p = 0; b_c = 0; b_p = 0;
    adj_a = 0; adj_b = 0; nr = 0; gap_bad = 0; last_p = 0;
    pa = 1'b0; pb = 1'b0;
    for (int k = 1; k <= 65536; k++) begin
      tick;
      a_c += int'(a_cpu);
      a_p += int'(a_pix);
      b_c += int'(b_cpu);
      b_p += int'(b_pix);
      if (k == 4096) a_c4k = a_c;
      if (a_cpu && pa) adj_a++;
      if (b_cpu && pb) adj_b++;
      if (a_cpu) begin
        if (last_p != 0 && k - last_p != 4) gap_bad++;
        last_p = k;
      end
      pa = a_cpu;
      pb = b_cpu;
      if (!a_run || !b_run) nr++;
    end
    check("a_cpu_4096_count", a_c4k, 1024);
    check("a_cpu_period4", gap_bad, 0);
    check("a_cpu_adjacent", adj_a, 0);
    check("a_cpu_65536_count", a_c, 16384);
    check("a_pix_65536_count", a_p, 34079);
    check("b_cpu_65536_count", b_c, 17039);
    check("b_pix_65536_count", b_p, 34079);
    check("b_cpu_adjacent", adj_b, 0);
    check("stayed_running", nr, 0);
    check("running_eq_reset", rr_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sys_reset_ce.md
Name: sys_reset_ce

Overview:
- Sits directly downstream of the system PLL and runs on its 12.5 MHz output.
- Synchronises the PLL `locked` flag and sequences a clean system reset.
- Generates fractional-rate single-cycle clock enables for the Z80 CPU (3.25 MHz) and the video pixel path (6.5 MHz), so everything downstream stays on one clock domain.

Parameters:
- LOCK_HOLD, 1024: consecutive synchronised-locked cycles required before reset is released; minimum 2.
- ACC_W, 16: phase-accumulator width in bits.
- CPU_INC, 17039: CPU-enable increment per clk; rate = clk × CPU_INC / 2^ACC_W (≈3.25 MHz at 12.5 MHz).
- PIX_INC, 34079: pixel-enable increment per clk (≈6.5 MHz).

Ports:
- clk  in  1  system clock, 12.5 MHz from the PLL secondary output.
- resetn  in  1  asynchronous active-low reset; asserted drives every register to its reset value immediately.
- locked  in  1  PLL lock flag; asynchronous to clk.
- soft_rst  in  1  synchronous, level-sensitive reset request (keyboard/button logic, already in the clk domain).
- sys_reset_n  out  1  registered active-low system reset for the downstream logic.
- cpu_ce  out  1  registered one-clk CPU enable pulse.
- pix_ce  out  1  registered one-clk pixel enable pulse.
- running  out  1  high in state RUN; registered, identical to sys_reset_n.

Behaviour:
- Reset values (resetn=0): state=WAIT_LOCK, sync flops=0, hold counter=0, both accumulators=0, sys_reset_n=0, cpu_ce=0, pix_ce=0, running=0.
- Lock synchroniser:
  - Two-flop synchroniser on `locked` produces lk_s.
  - FSM acts on lk_s only, so there is 2-edge latency.
- FSM states and transitions:
  - WAIT_LOCK: counter=0, accumulators held at 0, enables=0. Go to HOLD when lk_s=1.
  - HOLD: counter increments each clk.
    - lk_s=0 → WAIT_LOCK (takes priority).
    - Else soft_rst=1 → stay in HOLD with counter cleared to 0.
    - Else counter==LOCK_HOLD-1 → RUN.
  - RUN:
    - lk_s=0 → WAIT_LOCK.
    - Else soft_rst=1 → HOLD with counter=0.
- Output timing:
  - sys_reset_n and running are registered from the next-state decode. They rise on the same edge that enters RUN and fall on the same edge that leaves RUN.
  - Release latency: with the first edge sampling locked=1 counted as edge 1, sys_reset_n rises on edge LOCK_HOLD+3.
  - Assertion latency on lock loss: sys_reset_n falls on edge 3 after locked is first sampled low.
- NCO:
  - In HOLD and RUN, each clk: {carry, acc} ← acc + INC, computed (ACC_W+1) bits wide and truncated to ACC_W bits. Wrap-around is intended.
  - ce ← carry, registered on the same edge.
  - Enables therefore toggle during HOLD, so downstream synchronous resets complete.
- Enable rules:
  - Entering WAIT_LOCK clears acc and forces ce=0 on that edge.
  - Entering HOLD from RUN via soft_rst does not clear acc; enable phase is preserved.
  - INC=0 gives a constant 0 enable.
  - An enable is never high for two consecutive cycles when INC < 2^(ACC_W-1). PIX_INC ≥ 2^(ACC_W-1) is legal and may produce back-to-back pulses.
  - cpu_ce and pix_ce are independent. A simultaneous pulse on both is legal.
- Lock glitch: any lk_s low in HOLD or RUN, even one cycle, restarts the full sequence.
- resetn asserted mid-operation returns all registers to reset values asynchronously. Deassertion must be synchronous to clk; that is the upstream responsibility.

Decomposition:
- Package sys_clk_pkg holds:
  - the state enum {WAIT_LOCK, HOLD, RUN};
  - default CPU_INC/PIX_INC constants;
  - the ACC_W default.
- One sub-module, nco_ce (parameters ACC_W, INC; ports clk, resetn, run, clr, ce), instantiated twice.
- The lock synchroniser stays inline.

Test Plan:
1. LOCK_HOLD=8; hold locked=0 for 20 clk, then raise it → sys_reset_n=0 throughout the low period; sys_reset_n and running rise on edge 11 after first sampling locked=1; cpu_ce first pulses during HOLD.
2. In RUN, drop locked for 1 clk → sys_reset_n falls 3 edges later; sequence restarts; sys_reset_n rises again 11 edges after locked is resampled high.
3. ACC_W=16, CPU_INC=16384 → cpu_ce pulses exactly every 4th clk; over 4096 RUN cycles, exactly 1024 pulses, none adjacent.
4. Defaults → over 65536 RUN cycles, 17039 cpu_ce pulses (±1) and 34079 pix_ce pulses (±1).
5. soft_rst high 3 clk in RUN (LOCK_HOLD=8) → sys_reset_n falls on the next edge and stays low for 3+8 edges; accumulator phase continues without reset.
6. Assert resetn mid-HOLD asynchronously → all outputs 0 with no clock edge; after deassertion with locked=1, sys_reset_n rises 11 edges later.
